// File: rtl/pilha_pkg.sv
// Shared definitions for the data stack: command encodings and default word width.
// No logic; referenced by pilha_stack and pilha_regfile.
// Command encodings match what the control unit drives on its stack-write interface.
package pilha_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_PUSH     = 2'b01;
  localparam logic [1:0] CMD_POP      = 2'b10;
  localparam logic [1:0] CMD_REPLACE2 = 2'b11;

endpackage

// File: rtl/pilha_regfile.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port, two async read ports.
// Write takes effect on the rising edge; reads are combinational (zero latency).
// No backpressure; the caller guards every write. Contents are not reset.
module pilha_regfile
  import pilha_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port; storage has no reset so it maps onto plain flops or LUT RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/pilha_stack.sv
// Data stack responder for the control unit: PUSH / POP / REPLACE2 with TOS/NOS exposed to the datapath.
// Latency 1: command results (state, ack/err, flags) are visible the cycle after the command.
// Never stalls; a command that cannot complete is dropped and reported via err plus a sticky flag.
module pilha_stack
  import pilha_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int SP_W   = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              flush,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [DATA_W-1:0] pop_data,
  output logic [SP_W-1:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ack,
  output logic              err,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_ZERO = '0;
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  // sp counts entries; sp-1 addresses TOS, sp-2 addresses NOS.
  logic [SP_W-1:0]   sp;
  logic [AW-1:0]     idx_tos, idx_nos, waddr;
  logic [DATA_W-1:0] rd_tos, rd_nos;
  logic              live, issued;
  logic              push_ok, push_rej, pop_ok, pop_rej, rep_ok, rep_rej, we;

  // Indices wrap when sp<2, but the read data is masked off in that case.
  assign idx_tos = AW'(sp - SP_ONE);
  assign idx_nos = AW'(sp - SP_TWO);

  // Decode the command against the stack fill level; reset and flush suppress it entirely.
  always_comb begin
    live     = cmd_valid && !flush && !reset;
    issued   = live && (cmd != CMD_NOP);
    push_ok  = live && (cmd == CMD_PUSH) && (sp != SP_FULL);
    push_rej = live && (cmd == CMD_PUSH) && (sp == SP_FULL);
    pop_ok   = live && (cmd == CMD_POP) && (sp != SP_ZERO);
    pop_rej  = live && (cmd == CMD_POP) && (sp == SP_ZERO);
    rep_ok   = live && (cmd == CMD_REPLACE2) && (sp >= SP_TWO);
    rep_rej  = live && (cmd == CMD_REPLACE2) && (sp < SP_TWO);
    we       = push_ok || rep_ok;
    // REPLACE2 overwrites NOS (which becomes the new TOS); PUSH writes just above TOS.
    waddr    = rep_ok ? idx_nos : AW'(sp);
  end

  pilha_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_regfile (
    .clock  (clock),
    .we     (we),
    .waddr  (waddr),
    .wdata  (cmd_data),
    .raddr0 (idx_tos),
    .raddr1 (idx_nos),
    .rdata0 (rd_tos),
    .rdata1 (rd_nos)
  );

  // Stack pointer, pop result, handshake pulses and sticky flags; reset > flush > command.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp        <= SP_ZERO;
      pop_data  <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ack       <= issued;
      err       <= push_rej || pop_rej || rep_rej;
      overflow  <= overflow || push_rej;
      underflow <= underflow || pop_rej || rep_rej;
      if (flush)                 sp <= SP_ZERO;
      else if (push_ok)          sp <= sp + SP_ONE;
      else if (pop_ok || rep_ok) sp <= sp - SP_ONE;
      if (pop_ok) pop_data <= rd_tos;
    end
  end

  assign count = sp;
  assign empty = (sp == SP_ZERO);
  assign full  = (sp == SP_FULL);
  assign tos   = (sp != SP_ZERO) ? rd_tos : '0;
  assign nos   = (sp >= SP_TWO) ? rd_nos : '0;

endmodule

// File: tb/tb_pilha_stack.sv
// Bench for pilha_stack (DEPTH=4 so full/empty boundaries are hit often).
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_pilha_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH) + 1;

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_PSH = 2'b01;
  localparam logic [1:0] C_POP = 2'b10;
  localparam logic [1:0] C_REP = 2'b11;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd = 2'b00;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] tos, nos, pop_data;
  logic [SP_W-1:0]   count;
  logic              empty, full, ack, err, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the stack as a queue, back = top.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_pop;
  logic              m_ack, m_err, m_ovf, m_unf;

  pilha_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SP_W   (SP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_data  (cmd_data),
    .flush     (flush),
    .tos       (tos),
    .nos       (nos),
    .pop_data  (pop_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ack       (ack),
    .err       (err),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the model, then return #1 after the edge.
  task automatic step(input logic v, input logic [1:0] c, input logic [DATA_W-1:0] d,
                      input logic f, input logic r);
    logic [DATA_W-1:0] junk;
    cmd_valid = v; cmd = c; cmd_data = d; flush = f; reset = r;
    if (r) begin
      m_q.delete(); m_pop = '0; m_ack = 0; m_err = 0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      m_q.delete(); m_ack = 0; m_err = 0;
    end else begin
      m_ack = v && (c != C_NOP);
      m_err = 0;
      if (v && c == C_PSH) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else begin m_err = 1; m_ovf = 1; end
      end else if (v && c == C_POP) begin
        if (m_q.size() >= 1) m_pop = m_q.pop_back();
        else begin m_err = 1; m_unf = 1; end
      end else if (v && c == C_REP) begin
        if (m_q.size() >= 2) begin
          junk = m_q.pop_back(); junk = m_q.pop_back(); m_q.push_back(d);
        end else begin m_err = 1; m_unf = 1; end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, C_NOP, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, C_NOP, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({count, empty, full, tos, nos, pop_data} !== {3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b tos=%h nos=%h pop=%h want 0/1/0/00/00/00",
               count, empty, full, tos, nos, pop_data);
    end
    checks++;
    if ({ack, err, overflow, underflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got ack/err/ovf/unf=%b%b%b%b want 0000", ack, err, overflow, underflow);
    end
    idle();
    checks++;
    if ({count, empty, ack} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: got count=%0d empty=%b ack=%b want 0/1/0", count, empty, ack);
    end
  endtask

  task automatic test_push_replace_pop();
    step(1'b1, C_PSH, 8'h11, 1'b0, 1'b0);
    checks++;
    if ({count, tos, ack, err} !== {3'd1, 8'h11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL push1: got count=%0d tos=%h ack=%b err=%b want 1/11/1/0", count, tos, ack, err);
    end
    step(1'b1, C_PSH, 8'h22, 1'b0, 1'b0);
    checks++;
    if ({count, tos, nos, ack, err} !== {3'd2, 8'h22, 8'h11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL push2: got count=%0d tos=%h nos=%h ack=%b err=%b want 2/22/11/1/0",
               count, tos, nos, ack, err);
    end
    idle();
    checks++;
    if ({count, ack} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL ack_pulse: got count=%0d ack=%b want 2/0", count, ack);
    end
    step(1'b1, C_REP, 8'h33, 1'b0, 1'b0);
    checks++;
    if ({count, tos, nos, ack, err} !== {3'd1, 8'h33, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL replace2: got count=%0d tos=%h nos=%h ack=%b err=%b want 1/33/00/1/0",
               count, tos, nos, ack, err);
    end
    step(1'b1, C_POP, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({pop_data, count, empty, tos, ack, err} !== {8'h33, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pop_last: got pop=%h count=%0d empty=%b tos=%h ack=%b err=%b want 33/0/1/00/1/0",
               pop_data, count, empty, tos, ack, err);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, C_POP, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({ack, err, underflow, count, pop_data} !== {1'b1, 1'b1, 1'b1, 3'd0, 8'h33}) begin
      errors++;
      $display("FAIL pop_empty: got ack=%b err=%b unf=%b count=%0d pop=%h want 1/1/1/0/33",
               ack, err, underflow, count, pop_data);
    end
    idle();
    checks++;
    if ({ack, err, underflow} !== 3'b001) begin
      errors++;
      $display("FAIL unf_sticky: got ack=%b err=%b unf=%b want 0/0/1", ack, err, underflow);
    end
    step(1'b1, C_PSH, 8'h05, 1'b0, 1'b0);
    checks++;
    if ({ack, err, underflow, count, tos} !== {1'b1, 1'b0, 1'b1, 3'd1, 8'h05}) begin
      errors++;
      $display("FAIL push_after_unf: got ack=%b err=%b unf=%b count=%0d tos=%h want 1/0/1/1/05",
               ack, err, underflow, count, tos);
    end
    step(1'b1, C_REP, 8'h99, 1'b0, 1'b0);
    checks++;
    if ({ack, err, count, tos} !== {1'b1, 1'b1, 3'd1, 8'h05}) begin
      errors++;
      $display("FAIL rep_one_entry: got ack=%b err=%b count=%0d tos=%h want 1/1/1/05", ack, err, count, tos);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, C_NOP, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, C_PSH, 8'hA0 + 8'(i), 1'b0, 1'b0);
    checks++;
    if ({full, empty, count, tos, nos, err, overflow} !== {1'b1, 1'b0, 3'd4, 8'hA3, 8'hA2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fill: got full=%b empty=%b count=%0d tos=%h nos=%h err=%b ovf=%b want 1/0/4/A3/A2/0/0",
               full, empty, count, tos, nos, err, overflow);
    end
    step(1'b1, C_PSH, 8'hFF, 1'b0, 1'b0);
    checks++;
    if ({ack, err, overflow, count, tos, full} !== {1'b1, 1'b1, 1'b1, 3'd4, 8'hA3, 1'b1}) begin
      errors++;
      $display("FAIL push_full: got ack=%b err=%b ovf=%b count=%0d tos=%h full=%b want 1/1/1/4/A3/1",
               ack, err, overflow, count, tos, full);
    end
  endtask

  task automatic test_flush();
    step(1'b1, C_POP, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({count, pop_data, tos} !== {3'd3, 8'hA3, 8'hA2}) begin
      errors++;
      $display("FAIL pop_full: got count=%0d pop=%h tos=%h want 3/A3/A2", count, pop_data, tos);
    end
    step(1'b1, C_PSH, 8'h77, 1'b1, 1'b0);
    checks++;
    if ({count, empty, ack, err, overflow, underflow, tos} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL flush: got count=%0d empty=%b ack=%b err=%b ovf=%b unf=%b tos=%h want 0/1/0/0/1/1/00",
               count, empty, ack, err, overflow, underflow, tos);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, C_PSH, 8'h5A, 1'b0, 1'b0);
    step(1'b1, C_POP, 8'h00, 1'b0, 1'b0);
    step(1'b1, C_PSH, 8'h6B, 1'b0, 1'b0);
    step(1'b1, C_PSH, 8'h7C, 1'b1 ^ 1'b1, 1'b1);
    checks++;
    if ({count, empty, full, tos, nos, pop_data, ack, err, overflow, underflow} !==
        {3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d empty=%b tos=%h nos=%h pop=%h ack/err/ovf/unf=%b%b%b%b",
               count, empty, tos, nos, pop_data, ack, err, overflow, underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      step(1'b1, C_PSH, v, 1'b0, 1'b0);
      step(1'b1, C_POP, 8'(~v), 1'b0, 1'b0);
      checks++;
      if ({pop_data, count, ack, err} !== {v, 3'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL b2b_push_pop[%0d]: got pop=%h count=%0d ack=%b err=%b want %h/0/1/0",
                 i, pop_data, count, ack, err, v);
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] got, want;
    logic [1:0]  c;
    logic        f, r, v;
    logic [DATA_W-1:0] m_tos, m_nos;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) != 0);
      c = 2'($urandom);
      f = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, c, 8'($urandom), f, r);
      m_tos = (m_q.size() >= 1) ? m_q[m_q.size()-1] : '0;
      m_nos = (m_q.size() >= 2) ? m_q[m_q.size()-2] : '0;
      got  = {count, empty, full, tos, nos, pop_data, ack, err, overflow, underflow};
      want = {SP_W'(m_q.size()), (m_q.size() == 0), (m_q.size() == DEPTH), m_tos, m_nos, m_pop,
              m_ack, m_err, m_ovf, m_unf};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h (count,empty,full,tos,nos,pop,ack,err,ovf,unf)",
                 i, got, want);
      end
    end
  endtask

  initial begin
    m_pop = '0; m_ack = 0; m_err = 0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_push_replace_pop();
    test_underflow();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pilha_stack.md
Name: pilha_stack

Overview:
- Data stack ("pilha") that the control unit drives with push/pop commands: the responder end of the control unit's stack-write interface.
- Holds DEPTH words of DATA_W bits in a register file.
- Exposes top-of-stack (TOS) and next-on-stack (NOS) to the datapath for binary operations.
- Reports per-command acknowledge/error pulses and sticky overflow/underflow flags.

Parameters:
DATA_W, 8, data word width (matches data_mem width)
DEPTH, 16, number of stack entries, power of two, >= 2
SP_W, $clog2(DEPTH)+1, width of stack-pointer/count (0..DEPTH inclusive)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command strobe, one command per cycle
cmd  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE2
cmd_data  in  DATA_W  write data for PUSH / REPLACE2
flush  in  1  empty the stack in one cycle
tos  out  DATA_W  top-of-stack, 0 when count==0
nos  out  DATA_W  next-on-stack, 0 when count<2
pop_data  out  DATA_W  value removed by last successful POP, registered
count  out  SP_W  current number of entries
empty  out  1  count==0
full  out  1  count==DEPTH
ack  out  1  one-cycle pulse, cycle after any non-NOP command
err  out  1  one-cycle pulse with ack when command was rejected
overflow  out  1  sticky, set by PUSH while full
underflow  out  1  sticky, set by POP at count 0 or REPLACE2 at count<2

Behaviour:
- Reset (synchronous, active-high, highest priority): sp=0, pop_data=0, ack=0, err=0, overflow=0, underflow=0. Therefore tos=0, nos=0, count=0, empty=1, full=0. Register-file contents are not cleared.
- Priority: reset > flush > cmd_valid.
- flush: sp<=0; ack=0; the sticky flags are held; any concurrent cmd is ignored.
- All state updates occur on the rising clock edge. Results of a command are visible the cycle after it is presented (latency 1).
- PUSH, count<DEPTH: mem[sp]<=cmd_data; sp<=sp+1; ack=1.
- PUSH, full: no state change; ack=1, err=1, overflow<=1.
- POP, count>=1: pop_data<=mem[sp-1]; sp<=sp-1; ack=1.
- POP, empty: no change to sp or pop_data; ack=1, err=1, underflow<=1.
- REPLACE2 (binary op: pop two, push result), count>=2: mem[sp-2]<=cmd_data; sp<=sp-1; ack=1.
- REPLACE2, count<2: no change; ack=1, err=1, underflow<=1.
- NOP or cmd_valid=0: no state change; ack=0, err=0.
- tos = mem[sp-1] when sp>=1 else 0; nos = mem[sp-2] when sp>=2 else 0. Both are combinational from registered state; there are no stale values after pop.
- Index arithmetic uses SP_W bits. The memory index is sp-1 / sp-2 truncated to $clog2(DEPTH) bits and is only evaluated under the guard conditions above, so there is no wrap-around.
- cmd_data is sampled only on the accepting edge; it may change freely otherwise.
- Back-to-back commands every cycle are supported (e.g. PUSH then POP of the same value returns it).

Decomposition:
- Shared package pilha_pkg: cmd encodings (CMD_NOP, CMD_PUSH, CMD_POP, CMD_REPLACE2) as 2-bit localparams; DATA_W default.
- One sub-module, pilha_regfile: DEPTH x DATA_W register array with a single synchronous write port (we, waddr, wdata) and two combinational read ports (raddr0, raddr1). pilha_stack contains the sp counter, guards, flags and output muxing.

Test Plan:
- Reset then idle: count=0, empty=1, tos=0, nos=0, ack=0, overflow=0, underflow=0.
- PUSH 0x11, PUSH 0x22: count=2, tos=0x22, nos=0x11; ack high one cycle after each command, err=0.
- From that state, REPLACE2 with 0x33: count=1, tos=0x33, nos=0. Then POP: pop_data=0x33, count=0, empty=1.
- POP on empty: ack=1, err=1 for one cycle; underflow=1 and stays 1. Then PUSH 0x05 succeeds with err=0 and underflow still 1.
- DEPTH=4 override: 4 PUSHes (0xA0..0xA3) give full=1, tos=0xA3. A 5th PUSH 0xFF gives err=1, overflow=1, count=4, tos=0xA3.
- flush asserted together with a PUSH at count=3: next cycle count=0, empty=1, ack=0, sticky flags unchanged. Reset mid-sequence returns all outputs to their reset values.
